// File: rtl/amstrad_mem_arbiter_pkg.sv
// Shared definitions for the Amstrad memory arbiter.
//   gnt_t      : which requester owns the current memory access
//   state_t    : access sequencer states
//   lane_be    : byte-enable pattern for a byte access at a given address LSB
//   lane_byte  : selects the addressed byte out of a 16-bit memory word
package amstrad_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_LD   = 2'd3
    } gnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int VID_AW = 15;

    function automatic logic [1:0] lane_be(input logic a0);
        return a0 ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] lane_byte(input logic a0, input logic [15:0] w);
        return a0 ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/amstrad_req_latch.sv
// Request capture for one arbiter client: turns a pulse (or the rising edge of
// a level strobe) into a pending flag and stores the request payload.
//   clk, reset : clock, synchronous active-high reset
//   trig       : request pulse, or level strobe when EDGE_DET=1
//   en         : request accepted only while high
//   clr        : the arbiter has consumed the pending request
//   din        : payload sampled on acceptance
//   pending    : request waiting for service
//   payload    : latched payload
//   dup        : 1-clk pulse, a new request replaced one still pending
module amstrad_req_latch #(
    parameter int W        = 8,
    parameter bit EDGE_DET = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         trig,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         pending,
    output logic [W-1:0] payload,
    output logic         dup
);

    logic trig_d;
    logic fire;
    logic accept;

    always_comb begin
        fire   = EDGE_DET ? (trig & ~trig_d) : trig;
        accept = fire & en;
        // A request landing in the consume cycle is a fresh one, not an overrun.
        dup    = accept & pending & ~clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_d  <= 1'b0;
            pending <= 1'b0;
            payload <= '0;
        end else begin
            trig_d <= trig;
            if (accept) begin
                pending <= 1'b1;
                payload <= din;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/amstrad_mem_arbiter.sv
// Shares the 16-bit external memory port between video fetch, Z80 memory
// cycles and the ROM/snapshot loader, one access at a time, priority
// video > CPU > loader. Byte accesses become word accesses with byte enables.
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> cpu_rdata, cpu_done   (Z80 side)
//   vid_req/vid_addr                 -> vid_data, vid_valid, vid_ovr
//   ld_wr/ld_addr/ld_data            -> ld_busy
//   mem_req/mem_we/mem_addr/mem_be/mem_dout, mem_din          (SDRAM side)
module amstrad_mem_arbiter
    import amstrad_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_done,
    input  logic              vid_req,
    input  logic [14:0]       vid_addr,
    output logic [15:0]       vid_data,
    output logic              vid_valid,
    output logic              vid_ovr,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_dout,
    input  logic [15:0]       mem_din
);

    localparam int MW = ADDR_W - 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t  state, state_nxt;
    gnt_t    gnt, gnt_nxt;
    logic [CW-1:0] cnt;
    logic          rd_a0;

    logic                vid_pend, cpu_pend, ld_pend;
    logic [VID_AW-1:0]   vid_pl;
    logic [ADDR_W+8:0]   cpu_pl;
    logic [ADDR_W+7:0]   ld_pl;
    logic                vid_dup, cpu_dup_unused, ld_dup_unused;
    logic                clr_vid, clr_cpu, clr_ld;

    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_a, ld_a;
    logic [7:0]        cpu_d, ld_d;

    assign {cpu_we, cpu_a, cpu_d} = cpu_pl;
    assign {ld_a, ld_d}           = ld_pl;

    // Pending flags drop when the access is issued, so a request arriving while
    // its predecessor is still in flight queues behind it instead of merging.
    assign clr_vid = (state == ST_ISSUE) && (gnt == GNT_VID);
    assign clr_cpu = (state == ST_ISSUE) && (gnt == GNT_CPU);
    assign clr_ld  = (state == ST_ISSUE) && (gnt == GNT_LD);

    assign ld_busy = ld_pend | ((gnt == GNT_LD) && (state != ST_IDLE));

    amstrad_req_latch #(.W(VID_AW), .EDGE_DET(1'b0)) u_vid (
        .clk(clk), .reset(reset), .trig(vid_req), .en(1'b1), .clr(clr_vid),
        .din(vid_addr), .pending(vid_pend), .payload(vid_pl), .dup(vid_dup)
    );

    amstrad_req_latch #(.W(ADDR_W + 9), .EDGE_DET(1'b1)) u_cpu (
        .clk(clk), .reset(reset), .trig(cpu_rd | cpu_wr), .en(1'b1), .clr(clr_cpu),
        .din({cpu_wr, cpu_addr, cpu_wdata}), .pending(cpu_pend), .payload(cpu_pl),
        .dup(cpu_dup_unused)
    );

    amstrad_req_latch #(.W(ADDR_W + 8), .EDGE_DET(1'b0)) u_ld (
        .clk(clk), .reset(reset), .trig(ld_wr), .en(~ld_busy), .clr(clr_ld),
        .din({ld_addr, ld_data}), .pending(ld_pend), .payload(ld_pl),
        .dup(ld_dup_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            gnt   <= GNT_NONE;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_dout  = '0;
        case (state)
            ST_IDLE: begin
                if (vid_pend) begin
                    gnt_nxt   = GNT_VID;
                    state_nxt = ST_ISSUE;
                end else if (cpu_pend) begin
                    gnt_nxt   = GNT_CPU;
                    state_nxt = ST_ISSUE;
                end else if (ld_pend) begin
                    gnt_nxt   = GNT_LD;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req = 1'b1;
                case (gnt)
                    GNT_VID: begin
                        mem_addr = {{(MW - VID_AW){1'b0}}, vid_pl};
                        mem_be   = 2'b11;
                    end
                    GNT_CPU: begin
                        mem_we   = cpu_we;
                        mem_addr = cpu_a[ADDR_W-1:1];
                        mem_be   = lane_be(cpu_a[0]);
                        mem_dout = {cpu_d, cpu_d};
                    end
                    GNT_LD: begin
                        mem_we   = 1'b1;
                        mem_addr = ld_a[ADDR_W-1:1];
                        mem_be   = lane_be(ld_a[0]);
                        mem_dout = {ld_d, ld_d};
                    end
                    default: ;
                endcase
                state_nxt = mem_we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            rd_a0     <= 1'b0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            vid_ovr   <= 1'b0;
        end else begin
            cpu_done  <= 1'b0;
            vid_valid <= 1'b0;
            if (vid_dup) vid_ovr <= 1'b1;
            if (state == ST_ISSUE) begin
                cnt   <= CW'(MEM_LAT - 1);
                rd_a0 <= cpu_a[0];
                if ((gnt == GNT_CPU) && cpu_we) cpu_done <= 1'b1;
            end
            if (state == ST_WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else if (gnt == GNT_VID) begin
                    vid_data  <= mem_din;
                    vid_valid <= 1'b1;
                end else if (gnt == GNT_CPU) begin
                    cpu_rdata <= lane_byte(rd_a0, mem_din);
                    cpu_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
module tb_amstrad_mem_arbiter;

    localparam int ADDR_W  = 23;
    localparam int MEM_LAT = 2;

    logic              clk, reset;
    logic              cpu_rd, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata, cpu_rdata;
    logic              cpu_done;
    logic              vid_req;
    logic [14:0]       vid_addr;
    logic [15:0]       vid_data;
    logic              vid_valid, vid_ovr;
    logic              ld_wr;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_busy;
    logic              mem_req, mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [1:0]        mem_be;
    logic [15:0]       mem_dout, mem_din;

    amstrad_mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_ovr(vid_ovr),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_dout(mem_dout), .mem_din(mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-2:0] addr;
        logic              we;
        logic [1:0]        be;
        logic [15:0]       dout;
        int                cyc;
    } req_t;

    req_t        reqs[$];
    logic [15:0] vids[$];
    int          n_done, done_cyc, cyc;
    logic        busy_at_done;

    // Observer: samples DUT outputs 2 time units after each rising edge.
    initial begin
        cyc = 0; n_done = 0; done_cyc = 0; busy_at_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (mem_req)
                reqs.push_back('{addr: mem_addr, we: mem_we, be: mem_be, dout: mem_dout, cyc: cyc});
            if (vid_valid) vids.push_back(vid_data);
            if (cpu_done) begin
                n_done++;
                done_cyc     = cyc;
                busy_at_done = ld_busy;
            end
        end
    end

    // Memory model: read data = resp_base ^ word address, present only in the
    // cycle MEM_LAT after mem_req; junk otherwise.
    logic [15:0]       resp_base;
    int                lat_cnt;
    logic [ADDR_W-2:0] r_addr;
    initial begin
        mem_din = 16'hDEAD; lat_cnt = 0; r_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (lat_cnt == 1) mem_din = resp_base ^ r_addr[15:0];
            else              mem_din = 16'hDEAD;
            if (lat_cnt > 0) lat_cnt--;
            if (mem_req && !mem_we) begin
                lat_cnt = MEM_LAT;
                r_addr  = mem_addr;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        reqs.delete();
        vids.delete();
        n_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0; ld_wr = 0; ld_addr = '0; ld_data = '0;
        resp_base = '0;
        step(3);

        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_be",    mem_be,    0);
        check("rst_cpu_done",  cpu_done,  0);
        check("rst_vid_valid", vid_valid, 0);
        check("rst_vid_ovr",   vid_ovr,   0);
        check("rst_ld_busy",   ld_busy,   0);
        reset = 1'b0;
        step(2);

        // CPU read, odd byte 0x13 -> word 0x09, high lane
        clear_logs();
        resp_base = 16'hAB1B;            // word 0x09 reads back 0xAB12
        cpu_addr = 23'h00013; cpu_rd = 1'b1;
        step(8);
        cpu_rd = 1'b0;
        step(2);
        check("t1_req_n", reqs.size(), 1);
        if (reqs.size() == 1) begin
            check("t1_addr", reqs[0].addr, 22'h09);
            check("t1_be",   reqs[0].be,   2'b10);
            check("t1_we",   reqs[0].we,   0);
            // mem_din in cycle req+MEM_LAT, registered at that cycle's closing edge
            check("t1_lat",  done_cyc - reqs[0].cyc, MEM_LAT + 1);
        end
        check("t1_rdata",  cpu_rdata, 8'hAB);
        check("t1_done_n", n_done, 1);

        // CPU write held for 40 clk: one access only
        clear_logs();
        cpu_addr = 23'h00020; cpu_wdata = 8'h55; cpu_wr = 1'b1;
        step(40);
        cpu_wr = 1'b0;
        step(4);
        check("t2_req_n", reqs.size(), 1);
        if (reqs.size() == 1) begin
            check("t2_addr", reqs[0].addr, 22'h10);
            check("t2_we",   reqs[0].we,   1);
            check("t2_be",   reqs[0].be,   2'b01);
            check("t2_dout", reqs[0].dout, 16'h5555);
        end
        check("t2_done_n",     n_done, 1);
        check("t2_rdata_held", cpu_rdata, 8'hAB);

        // Three-way collision; second ld_wr while busy is dropped
        clear_logs();
        resp_base = 16'h1000;
        vid_addr = 15'h123; vid_req = 1'b1;
        cpu_addr = 23'h00041; cpu_rd = 1'b1;
        ld_addr = 23'h00100; ld_data = 8'h77; ld_wr = 1'b1;
        step(1);
        vid_req = 1'b0; ld_wr = 1'b0;
        check("t3_busy_set", ld_busy, 1);
        step(1);
        ld_addr = 23'h00300; ld_data = 8'h11; ld_wr = 1'b1;
        step(1);
        ld_wr = 1'b0;
        step(12);
        cpu_rd = 1'b0;
        step(3);
        check("t3_req_n", reqs.size(), 3);
        if (reqs.size() == 3) begin
            check("t3_g0_addr", reqs[0].addr, 22'h123);
            check("t3_g0_be",   reqs[0].be,   2'b11);
            check("t3_g1_addr", reqs[1].addr, 22'h20);
            check("t3_g1_be",   reqs[1].be,   2'b10);
            check("t3_g1_we",   reqs[1].we,   0);
            check("t3_g2_addr", reqs[2].addr, 22'h80);
            check("t3_g2_we",   reqs[2].we,   1);
            check("t3_g2_dout", reqs[2].dout, 16'h7777);
        end
        check("t3_vid_n", vids.size(), 1);
        if (vids.size() == 1) check("t3_vid_data", vids[0], 16'h1123);
        check("t3_rdata",        cpu_rdata, 8'h10);
        check("t3_busy_at_done", busy_at_done, 1);
        check("t3_busy_end",     ld_busy, 0);

        // Two vid_req one clock apart: overrun, single fetch at the newer address
        clear_logs();
        resp_base = 16'h2000;
        vid_addr = 15'h100; vid_req = 1'b1;
        step(1);
        vid_addr = 15'h101;
        step(1);
        vid_req = 1'b0;
        step(8);
        check("t4_ovr",   vid_ovr, 1);
        check("t4_req_n", reqs.size(), 1);
        if (reqs.size() == 1) check("t4_addr", reqs[0].addr, 22'h101);
        check("t4_vid_n", vids.size(), 1);
        if (vids.size() == 1) check("t4_vid_data", vids[0], 16'h2101);

        // Reset during WAIT aborts the fetch
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t5_ovr_clr", vid_ovr, 0);
        clear_logs();
        resp_base = 16'h3000;
        vid_addr = 15'h055; vid_req = 1'b1;
        step(1);
        vid_req = 1'b0;
        step(2);
        check("t5_issued", reqs.size(), 1);
        reset = 1'b1;
        step(1);
        check("t5_rst_req",   mem_req,  0);
        check("t5_rst_vdata", vid_data, 0);
        check("t5_rst_rdata", cpu_rdata, 0);
        reset = 1'b0;
        step(6);
        check("t5_no_valid", vids.size(), 0);
        vid_addr = 15'h066; vid_req = 1'b1;
        step(1);
        vid_req = 1'b0;
        step(6);
        check("t5_req_n", reqs.size(), 2);
        check("t5_vid_n", vids.size(), 1);
        if (vids.size() == 1) check("t5_vid_data", vids[0], 16'h3066);

        // Video request every 4 clk: full throughput, no overrun
        clear_logs();
        resp_base = 16'h4000;
        for (int i = 0; i < 6; i++) begin
            vid_addr = 15'h200 + 15'(i); vid_req = 1'b1;
            step(1);
            vid_req = 1'b0;
            step(3);
        end
        step(6);
        check("t6_ovr",   vid_ovr, 0);
        check("t6_req_n", reqs.size(), 6);
        check("t6_vid_n", vids.size(), 6);
        if (vids.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("t6_vid%0d", i), vids[i], 16'h4200 + i);

        // One-clock CPU write strobe to the top address while video wins arbitration
        clear_logs();
        vid_addr = 15'h7FFF; vid_req = 1'b1;
        cpu_addr = 23'h7FFFFF; cpu_wdata = 8'hC3; cpu_wr = 1'b1;
        step(1);
        vid_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        step(10);
        check("t7_req_n", reqs.size(), 2);
        if (reqs.size() == 2) begin
            check("t7_vaddr", reqs[0].addr, 22'h7FFF);
            check("t7_caddr", reqs[1].addr, 22'h3FFFFF);
            check("t7_cbe",   reqs[1].be,   2'b10);
            check("t7_cdout", reqs[1].dout, 16'hC3C3);
        end
        check("t7_done_n", n_done, 1);
        if (vids.size() == 1) check("t7_vid_data", vids[0], 16'h3FFF);
        else check("t7_vid_n", vids.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
